commit_trace_tx: RTL and testbench

COMMIT_TRACE_TX -- requirements
Module: commit_trace_tx

---
 rtl/commit_trace_tx.sv | 150 +++++++++++++++
 tb/tb_commit_trace_tx.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/commit_trace_tx.sv
// rtl/commit_trace_tx.sv - serialises register write-back commits into byte-wide trace frames
//
// Ports:
//   clk, reset      clock and asynchronous active-low reset
//   wb_en/wb_addr/wb_data/wb_pc   commit event from the core (r0 writes ignored)
//   tx_valid/tx_data/tx_ready     byte stream out, one frame per captured event
//   overflow, drop_cnt            sticky drop flag and saturating drop counter
// Frame: SYNC_BYTE, {3'b000,addr}, pc[31:0] MSB first, data[31:0] MSB first.
// Optional macro TRACE_CHECKSUM_EN appends an XOR checksum of bytes 1..9.
module commit_trace_tx #(
  parameter int          DEPTH     = 4,
  parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wb_en,
  input  logic [4:0]  wb_addr,
  input  logic [31:0] wb_data,
  input  logic [31:0] wb_pc,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  output logic        overflow,
  output logic [7:0]  drop_cnt
);

  localparam int AW = $clog2(DEPTH);
`ifdef TRACE_CHECKSUM_EN
  localparam int FRAME_LEN = 11;
`else
  localparam int FRAME_LEN = 10;
`endif
  // Bytes still to be sent after SYNC_BYTE, held in a left-shifting register.
  localparam int SHIFT_W = (FRAME_LEN - 1) * 8;
  localparam logic [3:0] LAST_IDX = 4'(FRAME_LEN - 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t             state_q, state_d;
  logic [3:0]         idx_q, idx_d;
  logic [SHIFT_W-1:0] shift_q, shift_d;
  logic               tx_valid_q, tx_valid_d;
  logic [7:0]         tx_data_q, tx_data_d;
  logic               overflow_q, overflow_d;
  logic [7:0]         drop_cnt_q, drop_cnt_d;
  logic [AW:0]        wr_ptr_q, wr_ptr_d;
  logic [AW:0]        rd_ptr_q, rd_ptr_d;
  logic [68:0]        mem_q [DEPTH];

  logic               capture, empty, full, pop, push, xfer;
  logic [68:0]        head;
  logic [71:0]        body;
  logic [SHIFT_W-1:0] shift_load;
`ifdef TRACE_CHECKSUM_EN
  logic [7:0]         chk;
`endif

  always_comb begin
    capture = wb_en && (wb_addr != 5'd0);
    empty   = (wr_ptr_q == rd_ptr_q);
    full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    // Emptiness uses registered pointers, so an entry pushed this cycle is
    // only visible for popping on the following edge.
    pop     = (state_q == IDLE) && !empty;
    // A pop frees a slot on the same edge, so a full FIFO can still accept.
    push    = capture && (!full || pop);
    xfer    = (state_q == SEND) && tx_ready;
    head    = mem_q[rd_ptr_q[AW-1:0]];
    body    = {3'b000, head};
`ifdef TRACE_CHECKSUM_EN
    chk = 8'h00;
    for (int i = 0; i < 9; i++) chk = chk ^ body[71-8*i -: 8];
    shift_load = {body, chk};
`else
    shift_load = body;
`endif

    state_d    = state_q;
    idx_d      = idx_q;
    shift_d    = shift_q;
    tx_valid_d = tx_valid_q;
    tx_data_d  = tx_data_q;
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;

    if (push) wr_ptr_d = wr_ptr_q + (AW+1)'(1);

    if (capture && !push) begin
      overflow_d = 1'b1;
      if (drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 8'd1;
    end

    if (pop) begin
      rd_ptr_d   = rd_ptr_q + (AW+1)'(1);
      state_d    = SEND;
      idx_d      = 4'd0;
      tx_valid_d = 1'b1;
      tx_data_d  = SYNC_BYTE;
      shift_d    = shift_load;
    end else if (xfer) begin
      if (idx_q == LAST_IDX) begin
        // Dropping to IDLE guarantees a one-cycle gap before the next pop.
        state_d    = IDLE;
        tx_valid_d = 1'b0;
        tx_data_d  = 8'h00;
      end else begin
        idx_d     = idx_q + 4'd1;
        tx_data_d = shift_q[SHIFT_W-1 -: 8];
        shift_d   = shift_q << 8;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      idx_q      <= 4'd0;
      shift_q    <= '0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= 8'h00;
      overflow_q <= 1'b0;
      drop_cnt_q <= 8'h00;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      shift_q    <= shift_d;
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  // Storage needs no reset: pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= {wb_addr, wb_pc, wb_data};
  end

  assign tx_valid = tx_valid_q;
  assign tx_data  = tx_data_q;
  assign overflow = overflow_q;
  assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_commit_trace_tx.sv
// tb/tb_commit_trace_tx.sv - directed self-checking bench for commit_trace_tx
module tb_commit_trace_tx;

`ifdef TRACE_CHECKSUM_EN
  localparam int FLEN = 11;
`else
  localparam int FLEN = 10;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        wb_en = 1'b0;
  logic [4:0]  wb_addr = '0;
  logic [31:0] wb_data = '0;
  logic [31:0] wb_pc = '0;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready = 1'b1;
  logic        overflow;
  logic [7:0]  drop_cnt;

  int checks = 0;
  int errors = 0;

  logic [7:0] got   [0:10];
  int         got_n;
  logic [7:0] exp_b [0:10];

  commit_trace_tx #(.DEPTH(4), .SYNC_BYTE(8'hA5)) dut (
    .clk(clk), .reset(reset), .wb_en(wb_en), .wb_addr(wb_addr),
    .wb_data(wb_data), .wb_pc(wb_pc), .tx_valid(tx_valid), .tx_data(tx_data),
    .tx_ready(tx_ready), .overflow(overflow), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic build_exp(input logic [4:0] a, input logic [31:0] pc, input logic [31:0] d);
    exp_b[0] = 8'hA5;
    exp_b[1] = {3'b000, a};
    for (int i = 0; i < 4; i++) begin
      exp_b[2+i] = pc[31-8*i -: 8];
      exp_b[6+i] = d[31-8*i -: 8];
    end
    exp_b[10] = 8'h00;
    for (int i = 1; i < 10; i++) exp_b[10] = exp_b[10] ^ exp_b[i];
  endtask

  // Called at a negedge; presents one commit and returns at the next negedge.
  task automatic commit(input logic [4:0] a, input logic [31:0] pc, input logic [31:0] d);
    wb_en = 1'b1; wb_addr = a; wb_pc = pc; wb_data = d;
    @(negedge clk);
    wb_en = 1'b0; wb_addr = '0; wb_pc = '0; wb_data = '0;
  endtask

  // Records bytes transferred (valid & ready at a negedge) until a frame is
  // complete or the budget runs out; returns at the negedge after the last byte.
  task automatic collect_frame(input int budget);
    got_n = 0;
    for (int c = 0; c < budget && got_n < FLEN; c++) begin
      if (tx_valid && tx_ready) begin
        got[got_n] = tx_data;
        got_n++;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL reset_tx_valid: got %b want 0", tx_valid); end
    checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data: got %h want 00", tx_data); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b want 0", overflow); end
    checks++; if (drop_cnt !== 8'h00) begin errors++; $display("FAIL reset_drop_cnt: got %h want 00", drop_cnt); end
    reset = 1'b1;
  endtask

  task automatic test_basic_frame;
    tx_ready = 1'b1;
    build_exp(5'd8, 32'h0000_0004, 32'h0000_000A);
    commit(5'd8, 32'h0000_0004, 32'h0000_000A);
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL latency_n1_valid: got %b want 0", tx_valid); end
    @(negedge clk);
    checks++; if (tx_valid !== 1'b1) begin errors++; $display("FAIL latency_n2_valid: got %b want 1", tx_valid); end
    checks++; if (tx_data !== 8'hA5) begin errors++; $display("FAIL latency_n2_sync: got %h want a5", tx_data); end
    collect_frame(40);
    checks++; if (got_n !== FLEN) begin errors++; $display("FAIL basic_len: got %0d want %0d", got_n, FLEN); end
    for (int i = 0; i < FLEN; i++) begin
      checks++;
      if (got[i] !== exp_b[i]) begin errors++; $display("FAIL basic_byte%0d: got %h want %h", i, got[i], exp_b[i]); end
    end
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL basic_gap: got %b want 0", tx_valid); end
  endtask

  task automatic test_r0_ignored;
    logic seen;
    seen = 1'b0;
    commit(5'd0, 32'h0000_0100, 32'hFFFF_FFFF);
    for (int c = 0; c < 8; c++) begin
      if (tx_valid) seen = 1'b1;
      @(negedge clk);
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL r0_frame: got %b want 0", seen); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL r0_overflow: got %b want 0", overflow); end
    checks++; if (drop_cnt !== 8'h00) begin errors++; $display("FAIL r0_drop_cnt: got %h want 00", drop_cnt); end
  endtask

  task automatic test_backpressure;
    int n;
    int stall;
    n = 0; stall = 0;
    tx_ready = 1'b1;
    build_exp(5'h13, 32'h1234_5678, 32'h9ABC_DEF0);
    commit(5'h13, 32'h1234_5678, 32'h9ABC_DEF0);
    for (int c = 0; c < 60 && n < FLEN; c++) begin
      if (tx_valid) begin
        if (n == 4 && stall < 5) begin
          tx_ready = 1'b0;
          checks++;
          if (tx_data !== 8'h56) begin errors++; $display("FAIL stall_hold%0d: got %h want 56", stall, tx_data); end
          stall++;
        end else begin
          tx_ready = 1'b1;
          got[n] = tx_data;
          n++;
        end
      end
      @(negedge clk);
    end
    tx_ready = 1'b1;
    checks++; if (n !== FLEN) begin errors++; $display("FAIL stall_len: got %0d want %0d", n, FLEN); end
    for (int i = 0; i < FLEN; i++) begin
      checks++;
      if (got[i] !== exp_b[i]) begin errors++; $display("FAIL stall_byte%0d: got %h want %h", i, got[i], exp_b[i]); end
    end
  endtask

  task automatic test_overflow;
    logic seen;
    tx_ready = 1'b0;
    for (int i = 1; i <= 7; i++)
      commit(5'(i), 32'h1000_0000 + 32'(i * 4), 32'hC0DE_0000 | 32'(i));
    @(negedge clk);
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b want 1", overflow); end
    checks++; if (drop_cnt !== 8'd2) begin errors++; $display("FAIL ovf_drop_cnt: got %0d want 2", drop_cnt); end
    tx_ready = 1'b1;
    for (int f = 1; f <= 5; f++) begin
      build_exp(5'(f), 32'h1000_0000 + 32'(f * 4), 32'hC0DE_0000 | 32'(f));
      collect_frame(60);
      checks++; if (got_n !== FLEN) begin errors++; $display("FAIL ovf_frame%0d_len: got %0d want %0d", f, got_n, FLEN); end
      for (int i = 0; i < FLEN; i++) begin
        checks++;
        if (got[i] !== exp_b[i]) begin errors++; $display("FAIL ovf_frame%0d_byte%0d: got %h want %h", f, i, got[i], exp_b[i]); end
      end
    end
    seen = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (tx_valid) seen = 1'b1;
      @(negedge clk);
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL ovf_extra_frame: got %b want 0", seen); end
    checks++; if (drop_cnt !== 8'd2) begin errors++; $display("FAIL ovf_drop_sticky: got %0d want 2", drop_cnt); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag_sticky: got %b want 1", overflow); end
  endtask

  task automatic test_reset_midframe;
    int n;
    logic reached;
    n = 0; reached = 1'b0;
    tx_ready = 1'b1;
    commit(5'd9, 32'hDEAD_BEEF, 32'h0BAD_F00D);
    for (int c = 0; c < 40; c++) begin
      if (tx_valid && tx_ready) begin
        if (n == 6) begin reached = 1'b1; break; end
        n++;
      end
      @(negedge clk);
    end
    checks++; if (reached !== 1'b1) begin errors++; $display("FAIL midrst_reach_byte6: got %b want 1", reached); end
    reset = 1'b0;
    #1;
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL midrst_tx_valid: got %b want 0", tx_valid); end
    checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL midrst_tx_data: got %h want 00", tx_data); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL midrst_overflow: got %b want 0", overflow); end
    checks++; if (drop_cnt !== 8'h00) begin errors++; $display("FAIL midrst_drop_cnt: got %h want 00", drop_cnt); end
    @(negedge clk);
    reset = 1'b1;
    build_exp(5'd31, 32'hCAFE_0010, 32'h8765_4321);
    commit(5'd31, 32'hCAFE_0010, 32'h8765_4321);
    collect_frame(40);
    checks++; if (got_n !== FLEN) begin errors++; $display("FAIL midrst_new_len: got %0d want %0d", got_n, FLEN); end
    for (int i = 0; i < FLEN; i++) begin
      checks++;
      if (got[i] !== exp_b[i]) begin errors++; $display("FAIL midrst_new_byte%0d: got %h want %h", i, got[i], exp_b[i]); end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset;
    test_basic_frame;
    test_r0_ignored;
    test_backpressure;
    test_overflow;
    test_reset_midframe;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
